// File: rtl/fetch_sequencer_if.sv
// Memory and core handshake bundle between fetch_sequencer (master) and the
// instruction memory / bitty core (slave).
interface fetch_sequencer_if;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        core_run;
  logic        core_done;
  logic [15:0] alu_result;

  modport master (
    output mem_addr, instr, core_run,
    input  mem_data, core_done, alu_result
  );

  modport slave (
    input  mem_addr, instr, core_run,
    output mem_data, core_done, alu_result
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the pc, drives the synchronous
// instruction memory, issues instructions to the core, resolves branches,
// detects halt and runs a watchdog on the core's done.
// Optional macro RETIRE_COUNT_EN adds the saturating retired counter.
module fetch_sequencer #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF,
  parameter int          TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  fetch_sequencer_if.master   bus,
  output logic [7:0]          pc,
  output logic                halted,
`ifdef RETIRE_COUNT_EN
  output logic [15:0]         retired,
`endif
  output logic                error
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    HALT,
    ERR
  } state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [7:0]  wdog_q;
  logic [15:0] instr_q;
  logic        core_run_q;
  logic        halted_q;
  logic        error_q;

  logic [7:0]  pc_inc_d;
  logic [7:0]  wdog_d;
  logic        timeout_hit_d;
  logic        branch_taken_d;
  logic        issue_d;
  state_t      resume_d;

  // core_run is registered, so the issue decision is made on the word
  // arriving from memory in WAIT; the pulse then lines up with DECODE.
  always_comb begin
    pc_inc_d       = pc_q + 8'd1;
    wdog_d         = wdog_q + 8'd1;
    timeout_hit_d  = ({1'b0, wdog_q} + 9'd1) == TIMEOUT_W;
    issue_d        = (bus.mem_data != HALT_WORD) && (bus.mem_data[1:0] != 2'b10);
    resume_d       = run ? FETCH : IDLE;
    branch_taken_d = 1'b0;
    case (instr_q[3:2])
      2'b00:   branch_taken_d = (bus.alu_result == 16'h0000);
      2'b01:   branch_taken_d = !bus.alu_result[15] && (bus.alu_result != 16'h0000);
      2'b10:   branch_taken_d = bus.alu_result[15];
      default: branch_taken_d = 1'b1;
    endcase
  end

`ifdef RETIRE_COUNT_EN
  logic [15:0] retired_q;
  logic [15:0] retired_d;

  always_comb begin
    retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 16'h0000;
    end else if ((state_q == DECODE && instr_q != HALT_WORD && instr_q[1:0] == 2'b10) ||
                 (state_q == EXEC && bus.core_done)) begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= START_ADDR;
      wdog_q     <= 8'd0;
      instr_q    <= 16'h0000;
      core_run_q <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      core_run_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) state_q <= FETCH;
        end
        FETCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          instr_q    <= bus.mem_data;
          core_run_q <= issue_d;
          state_q    <= DECODE;
        end
        DECODE: begin
          if (instr_q == HALT_WORD) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else if (instr_q[1:0] == 2'b10) begin
            pc_q    <= branch_taken_d ? instr_q[11:4] : pc_inc_d;
            state_q <= resume_d;
          end else begin
            wdog_q  <= 8'd0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // A done arriving on the timeout cycle wins over the watchdog.
          wdog_q <= wdog_d;
          if (bus.core_done) begin
            pc_q    <= pc_inc_d;
            state_q <= resume_d;
          end else if (timeout_hit_d) begin
            error_q <= 1'b1;
            state_q <= ERR;
          end
        end
        HALT, ERR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr = pc_q;
  assign bus.instr    = instr_q;
  assign bus.core_run = core_run_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: one instance at START 0 /
// TIMEOUT 4 with a programmable core model, one at START FF for pc wrap.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  logic run0;
  logic run1;
  logic [7:0] pc0, pc1;
  logic halted0, halted1;
  logic error0, error1;
`ifdef RETIRE_COUNT_EN
  logic [15:0] retired0, retired1;
`endif

  fetch_sequencer_if bus0 ();
  fetch_sequencer_if bus1 ();

  fetch_sequencer #(.START_ADDR(8'h00), .HALT_WORD(16'hFFFF), .TIMEOUT(4)) dut0 (
    .clk(clk), .reset(reset), .run(run0), .bus(bus0),
    .pc(pc0), .halted(halted0),
`ifdef RETIRE_COUNT_EN
    .retired(retired0),
`endif
    .error(error0)
  );

  fetch_sequencer #(.START_ADDR(8'hFF), .HALT_WORD(16'hFFFF), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset), .run(run1), .bus(bus1),
    .pc(pc1), .halted(halted1),
`ifdef RETIRE_COUNT_EN
    .retired(retired1),
`endif
    .error(error1)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus0.mem_data <= mem0[bus0.mem_addr];
    bus1.mem_data <= mem1[bus1.mem_addr];
  end

  // Core model for dut0: done arrives in EXEC cycle doneCycle0 (0 = never).
  int doneCycle0 = 2;
  int cnt0 = 0;
  logic busy0 = 1'b0;
  int runCount0 = 0;
  int pulseErr0 = 0;
  logic prevRun0 = 1'b0;
  logic [15:0] instrLog0 [16];

  always @(posedge clk) begin
    prevRun0 <= bus0.core_run;
    if (bus0.core_run && prevRun0) pulseErr0 <= pulseErr0 + 1;
    if (bus0.core_run) begin
      instrLog0[runCount0 % 16] <= bus0.instr;
      runCount0 <= runCount0 + 1;
    end
    if (reset) begin
      bus0.core_done <= 1'b0;
      busy0 <= 1'b0;
      cnt0 <= 0;
    end else if (bus0.core_run) begin
      cnt0 <= 1;
      busy0 <= (doneCycle0 != 1);
      bus0.core_done <= (doneCycle0 == 1);
    end else if (busy0) begin
      cnt0 <= cnt0 + 1;
      bus0.core_done <= (doneCycle0 == cnt0 + 1);
      if (doneCycle0 == cnt0 + 1) busy0 <= 1'b0;
    end else begin
      bus0.core_done <= 1'b0;
    end
  end

  // Core model for dut1: done in the first EXEC cycle.
  int runCount1 = 0;
  always @(posedge clk) begin
    if (reset) begin
      bus1.core_done <= 1'b0;
    end else begin
      bus1.core_done <= bus1.core_run;
      if (bus1.core_run) runCount1 <= runCount1 + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMem0();
    for (int i = 0; i < 256; i++) mem0[i] = 16'hFFFF;
  endtask

  task automatic applyStimulus(input logic runVal, input logic [15:0] alu, input int doneCycle);
    reset = 1'b1;
    step(2);
    run0 = runVal;
    bus0.alu_result = alu;
    doneCycle0 = doneCycle;
    reset = 1'b0;
  endtask

  task automatic waitHalted0(input string tag);
    int n;
    n = 0;
    while (!halted0 && n < 80) begin
      step(1);
      n++;
    end
    checkOutput(tag, 32'(halted0), 32'd1);
  endtask

  task automatic branchCase(input string tag, input logic [15:0] word, input logic [15:0] alu,
                            input logic [7:0] expPc);
    int base;
    clearMem0();
    mem0[0] = word;
    base = runCount0;
    applyStimulus(1'b1, alu, 0);
    step(3);
    checkOutput({tag, "_decode_norun"}, 32'(bus0.core_run), 32'd0);
    step(1);
    checkOutput({tag, "_pc"}, 32'(pc0), 32'(expPc));
    step(8);
    checkOutput({tag, "_noissue"}, 32'(runCount0 - base), 32'd0);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    run0 = 1'b0;
    run1 = 1'b0;
    bus0.alu_result = 16'h0000;
    bus1.alu_result = 16'h0000;
    clearMem0();
    for (int i = 0; i < 256; i++) mem1[i] = 16'hFFFF;
    step(2);

    checkOutput("rst_pc", 32'(pc0), 32'h00);
    checkOutput("rst_instr", 32'(bus0.instr), 32'h0000);
    checkOutput("rst_core_run", 32'(bus0.core_run), 32'd0);
    checkOutput("rst_halted", 32'(halted0), 32'd0);
    checkOutput("rst_error", 32'(error0), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus0.mem_addr), 32'h00);
    checkOutput("rst_pc_start_ff", 32'(pc1), 32'hFF);

    // Two plain instructions then halt; core answers in EXEC cycle 2.
    mem0[0] = 16'h0001;
    mem0[1] = 16'h0005;
    mem0[2] = 16'hFFFF;
    base = runCount0;
    applyStimulus(1'b1, 16'h0000, 2);
    step(3);
    checkOutput("basic_first_run", 32'(bus0.core_run), 32'd1);
    checkOutput("basic_first_instr", 32'(bus0.instr), 32'h0001);
    step(1);
    checkOutput("basic_run_pulse", 32'(bus0.core_run), 32'd0);
    waitHalted0("basic_halted");
    checkOutput("basic_pc", 32'(pc0), 32'h02);
    checkOutput("basic_count", 32'(runCount0 - base), 32'd2);
    checkOutput("basic_instr0", 32'(instrLog0[base % 16]), 32'h0001);
    checkOutput("basic_instr1", 32'(instrLog0[(base + 1) % 16]), 32'h0005);
`ifdef RETIRE_COUNT_EN
    checkOutput("basic_retired", 32'(retired0), 32'd2);
`endif
    step(10);
    checkOutput("basic_no_more_run", 32'(runCount0 - base), 32'd2);
    checkOutput("basic_pc_frozen", 32'(pc0), 32'h02);

    branchCase("br_eq_taken", 16'h0A02, 16'h0000, 8'hA0);
    branchCase("br_eq_not", 16'h0A02, 16'h0003, 8'h01);
    branchCase("br_always", 16'h0A0E, 16'h0003, 8'hA0);
    branchCase("br_pos_taken", 16'h0A06, 16'h0005, 8'hA0);
    branchCase("br_pos_neg", 16'h0A06, 16'h8000, 8'h01);
    branchCase("br_pos_zero", 16'h0A06, 16'h0000, 8'h01);
    branchCase("br_neg_taken", 16'h0A0A, 16'h8000, 8'hA0);
    branchCase("br_neg_not", 16'h0A0A, 16'h7FFF, 8'h01);
`ifdef RETIRE_COUNT_EN
    checkOutput("br_retired", 32'(retired0), 32'd1);
`endif

    // Watchdog: core never answers, error on the 4th edge after EXEC entry.
    clearMem0();
    mem0[0] = 16'h0001;
    base = runCount0;
    applyStimulus(1'b1, 16'h0000, 0);
    step(3);
    step(4);
    checkOutput("wd_exec4_noerr", 32'(error0), 32'd0);
    step(1);
    checkOutput("wd_error", 32'(error0), 32'd1);
    checkOutput("wd_pc", 32'(pc0), 32'h00);
    step(5);
    checkOutput("wd_sticky", 32'(error0), 32'd1);
    checkOutput("wd_pc_frozen", 32'(pc0), 32'h00);
    checkOutput("wd_no_reissue", 32'(runCount0 - base), 32'd1);

    // Watchdog boundary: done on the 4th EXEC cycle is completion.
    clearMem0();
    mem0[0] = 16'h0001;
    mem0[1] = 16'hFFFF;
    applyStimulus(1'b1, 16'h0000, 4);
    checkOutput("wdb_err_cleared", 32'(error0), 32'd0);
    step(3);
    step(4);
    checkOutput("wdb_done_seen", 32'(bus0.core_done), 32'd1);
    step(1);
    checkOutput("wdb_noerr", 32'(error0), 32'd0);
    checkOutput("wdb_pc", 32'(pc0), 32'h01);
    waitHalted0("wdb_halted");
    checkOutput("wdb_noerr_end", 32'(error0), 32'd0);

    // Run dropped during EXEC: finish, park with pc+1, resume there.
    clearMem0();
    mem0[0] = 16'h0001;
    mem0[1] = 16'h0005;
    base = runCount0;
    applyStimulus(1'b1, 16'h0000, 3);
    step(4);
    run0 = 1'b0;
    step(6);
    checkOutput("drop_pc", 32'(pc0), 32'h01);
    checkOutput("drop_count", 32'(runCount0 - base), 32'd1);
    checkOutput("drop_not_halted", 32'(halted0), 32'd0);
    run0 = 1'b1;
    step(3);
    checkOutput("resume_run", 32'(bus0.core_run), 32'd1);
    checkOutput("resume_instr", 32'(bus0.instr), 32'h0005);
    waitHalted0("resume_halted");
    checkOutput("resume_pc", 32'(pc0), 32'h02);

    // Reset while the core is busy in EXEC.
    clearMem0();
    mem0[0] = 16'h0302;
    mem0[8'h30] = 16'h0001;
    applyStimulus(1'b1, 16'h0000, 0);
    step(7);
    checkOutput("rstx_pc_before", 32'(pc0), 32'h30);
    step(1);
    reset = 1'b1;
    step(1);
    checkOutput("rstx_pc", 32'(pc0), 32'h00);
    checkOutput("rstx_core_run", 32'(bus0.core_run), 32'd0);
    checkOutput("rstx_instr", 32'(bus0.instr), 32'h0000);
    checkOutput("rstx_halted", 32'(halted0), 32'd0);
    checkOutput("rstx_error", 32'(error0), 32'd0);
    run0 = 1'b0;
    reset = 1'b0;
    step(4);
    checkOutput("idle_hold_pc", 32'(pc0), 32'h00);

    // pc wrap on START_ADDR=FF instance.
    mem1[8'hFF] = 16'h0001;
    mem1[8'h00] = 16'hFFFF;
    base = runCount1;
    reset = 1'b1;
    step(2);
    run1 = 1'b1;
    reset = 1'b0;
    step(3);
    checkOutput("wrap_issue", 32'(bus1.core_run), 32'd1);
    step(2);
    checkOutput("wrap_pc", 32'(pc1), 32'h00);
    checkOutput("wrap_mem_addr", 32'(bus1.mem_addr), 32'h00);
    step(6);
    checkOutput("wrap_halted", 32'(halted1), 32'd1);
    checkOutput("wrap_pc_end", 32'(pc1), 32'h00);
    checkOutput("wrap_count", 32'(runCount1 - base), 32'd1);
    checkOutput("wrap_noerr", 32'(error1), 32'd0);

    checkOutput("run_pulse_width", 32'(pulseErr0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
